// File: rtl/tick_sched.sv
// Multi-channel tick-counting timer scheduler with round-robin event arbitration onto one port.
// Latency: expiry registered at edge N, event presented at edge N+1; one event per cycle sustained.
// Backpressure: event held stable while evt_ready=0; repeat expiries set the sticky per-channel overrun.
module tick_sched #(
    parameter int NCH = 4,
    parameter int IDW = 2,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rstb,
    input  logic           tick,
    input  logic           cfg_we,
    input  logic [IDW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_period,
    input  logic           cfg_periodic,
    input  logic [NCH-1:0] ovr_clr,
    output logic           evt_valid,
    output logic [IDW-1:0] evt_id,
    input  logic           evt_ready,
    output logic [NCH-1:0] active,
    output logic [NCH-1:0] overrun
);

    logic [CW-1:0]  period [NCH];
    logic [CW-1:0]  cnt    [NCH];
    logic [NCH-1:0] periodic;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] cfg_hit;
    logic [NCH-1:0] expire;
    logic [NCH-1:0] gnt_vec;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] rr_nxt;
    logic [IDW:0]   gnt_inc;
    logic           slot_free;
    logic           gnt_any;
    int             idx;

    // A config write to a channel overrides any tick seen in the same cycle.
    always_comb begin
        cfg_hit = '0;
        expire  = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            cfg_hit[ch] = cfg_we && (cfg_ch == IDW'(ch));
            expire[ch]  = tick && active[ch] && !cfg_hit[ch] && (cnt[ch] == CW'(1));
        end
    end

    assign slot_free = !evt_valid || evt_ready;

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        gnt_vec = '0;
        idx     = 0;
        if (slot_free) begin
            for (int i = 0; i < NCH; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= NCH) idx = idx - NCH;
                if (!gnt_any && pending[IDW'(idx)]) begin
                    gnt_any = 1'b1;
                    gnt_id  = IDW'(idx);
                end
            end
        end
        if (gnt_any) gnt_vec[gnt_id] = 1'b1;
    end

    assign gnt_inc = {1'b0, gnt_id} + (IDW+1)'(1);
    assign rr_nxt  = (gnt_inc == (IDW+1)'(NCH)) ? '0 : gnt_inc[IDW-1:0];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int ch = 0; ch < NCH; ch++) begin
                period[ch] <= '0;
                cnt[ch]    <= '0;
            end
            periodic <= '0;
            active   <= '0;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (cfg_hit[ch]) begin
                    period[ch]   <= cfg_period;
                    periodic[ch] <= cfg_periodic;
                    cnt[ch]      <= cfg_period;
                    active[ch]   <= (cfg_period != '0);
                end else if (tick && active[ch]) begin
                    if (cnt[ch] == CW'(1)) begin
                        if (periodic[ch]) begin
                            cnt[ch] <= period[ch];
                        end else begin
                            cnt[ch]    <= '0;
                            active[ch] <= 1'b0;
                        end
                    end else begin
                        cnt[ch] <= cnt[ch] - CW'(1);
                    end
                end
            end
        end
    end

    // A grant and a fresh expiry on the same channel leave it pending without an overrun.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= (pending & ~gnt_vec) | expire;
            overrun <= (overrun & ~ovr_clr) | (expire & pending & ~gnt_vec);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            rr_ptr    <= '0;
        end else if (slot_free) begin
            if (gnt_any) begin
                evt_valid <= 1'b1;
                evt_id    <= gnt_id;
                rr_ptr    <= rr_nxt;
            end else begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched: reset, one-shot, periodic, round-robin, backpressure/overrun, config conflicts.
module tb_tick_sched;

    logic       clk;
    logic       rstb;
    logic       tick;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [15:0] cfg_period;
    logic       cfg_periodic;
    logic [3:0] ovr_clr;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_ready;
    logic [3:0] active;
    logic [3:0] overrun;

    int vectors = 0;
    int miscompares = 0;
    int nevt;
    int badid;

    tick_sched #(.NCH(4), .IDW(2), .CW(16)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .tick         (tick),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_period   (cfg_period),
        .cfg_periodic (cfg_periodic),
        .ovr_clr      (ovr_clr),
        .evt_valid    (evt_valid),
        .evt_id       (evt_id),
        .evt_ready    (evt_ready),
        .active       (active),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tk();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [15:0] per, input logic pdc);
        cfg_we       = 1'b1;
        cfg_ch       = ch;
        cfg_period   = per;
        cfg_periodic = pdc;
        cyc();
        cfg_we       = 1'b0;
    endtask

    initial begin
        rstb = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
        cfg_periodic = 1'b0; ovr_clr = '0; evt_ready = 1'b1;
        cyc(); cyc();
        chk("rst_valid", 32'(evt_valid), 32'h0);
        chk("rst_id", 32'(evt_id), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        rstb = 1'b1;
        cyc();

        // One-shot on channel 1, period 3.
        cfg(2'd1, 16'd3, 1'b0);
        chk("t2_active_on", 32'(active), 32'h2);
        tk(); tk();
        chk("t2_no_evt_early", 32'(evt_valid), 32'h0);
        tk();
        chk("t2_active_drop", 32'(active), 32'h0);
        chk("t2_valid_latency", 32'(evt_valid), 32'h0);
        cyc();
        chk("t2_valid", 32'(evt_valid), 32'h1);
        chk("t2_id", 32'(evt_id), 32'h1);
        cyc();
        chk("t2_single_pulse", 32'(evt_valid), 32'h0);

        // Periodic on channel 0, period 2, 10 ticks -> 5 events.
        cfg(2'd0, 16'd2, 1'b1);
        nevt = 0; badid = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 10) tk(); else cyc();
            if (evt_valid) begin
                nevt++;
                if (evt_id !== 2'd0) badid++;
            end
        end
        chk("t3_count", 32'(nevt), 32'd5);
        chk("t3_ids", 32'(badid), 32'd0);
        chk("t3_overrun", 32'(overrun), 32'h0);
        cfg(2'd0, 16'd0, 1'b0);
        chk("t3_disabled", 32'(active), 32'h0);

        // Reset mid-operation with an event held by backpressure.
        evt_ready = 1'b0;
        cfg(2'd2, 16'd1, 1'b1);
        tk();
        cyc();
        chk("t1_held_valid", 32'(evt_valid), 32'h1);
        chk("t1_held_id", 32'(evt_id), 32'h2);
        rstb = 1'b0;
        #2;
        chk("t1_async_valid", 32'(evt_valid), 32'h0);
        chk("t1_async_id", 32'(evt_id), 32'h0);
        chk("t1_async_active", 32'(active), 32'h0);
        chk("t1_async_overrun", 32'(overrun), 32'h0);
        rstb = 1'b1;
        evt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tk();
            chk("t1_quiet_valid", 32'(evt_valid), 32'h0);
        end
        chk("t1_quiet_active", 32'(active), 32'h0);

        // Round robin: all four channels expire together, twice.
        for (int c = 0; c < 4; c++) cfg(2'(c), 16'd1, 1'b1);
        chk("t4_all_active", 32'(active), 32'hf);
        for (int r = 0; r < 2; r++) begin
            tk();
            chk("t4_latency", 32'(evt_valid), 32'h0);
            for (int c = 0; c < 4; c++) begin
                cyc();
                chk("t4_valid", 32'(evt_valid), 32'h1);
                chk("t4_order", 32'(evt_id), 32'(c));
            end
            cyc();
            chk("t4_drain", 32'(evt_valid), 32'h0);
        end
        chk("t4_overrun", 32'(overrun), 32'h0);
        for (int c = 0; c < 4; c++) cfg(2'(c), 16'd0, 1'b0);
        chk("t4_disabled", 32'(active), 32'h0);

        // Backpressure and overrun on channel 2.
        evt_ready = 1'b0;
        cfg(2'd2, 16'd1, 1'b1);
        tk(); tk(); tk();
        chk("t5_valid", 32'(evt_valid), 32'h1);
        chk("t5_id", 32'(evt_id), 32'h2);
        chk("t5_overrun", 32'(overrun), 32'h4);
        tick = 1'b1; ovr_clr = 4'b0100;
        cyc();
        tick = 1'b0; ovr_clr = '0;
        chk("t5_set_wins", 32'(overrun), 32'h4);
        chk("t5_id_stable", 32'(evt_id), 32'h2);
        ovr_clr = 4'b0100;
        cyc();
        ovr_clr = '0;
        chk("t5_cleared", 32'(overrun), 32'h0);
        chk("t5_still_held", 32'(evt_valid), 32'h1);
        cfg(2'd2, 16'd0, 1'b0);
        chk("t6_disable_active", 32'(active), 32'h0);
        chk("t6_disable_held", 32'(evt_valid), 32'h1);
        evt_ready = 1'b1;
        cyc();
        chk("t6_pending_delivered", 32'(evt_valid), 32'h1);
        chk("t6_pending_id", 32'(evt_id), 32'h2);
        cyc();
        chk("t6_drain", 32'(evt_valid), 32'h0);

        // Config write to channel 3 coinciding with a tick reloads without decrement.
        cfg(2'd3, 16'd5, 1'b0);
        tk(); tk();
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_period = 16'd2; cfg_periodic = 1'b0; tick = 1'b1;
        cyc();
        cfg_we = 1'b0; tick = 1'b0;
        chk("t6_conflict_active", 32'(active), 32'h8);
        tk();
        cyc();
        chk("t6_no_early_evt", 32'(evt_valid), 32'h0);
        chk("t6_still_active", 32'(active), 32'h8);
        tk();
        chk("t6_oneshot_drop", 32'(active), 32'h0);
        cyc();
        chk("t6_evt_valid", 32'(evt_valid), 32'h1);
        chk("t6_evt_id", 32'(evt_id), 32'h3);
        cyc();
        chk("t6_evt_done", 32'(evt_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
